// File: rtl/keypad_entry.sv
// Keypad entry stage: collects key digits into a 5-digit buffer and presents
// whole codes on submit, with clear/backspace/enter, inactivity timeout and lockout.
module keypad_entry #(
  parameter int NUM_DIGITS  = 5,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               lockout,
  output logic [DIGIT_W-1:0] digit_a,
  output logic [DIGIT_W-1:0] digit_b,
  output logic [DIGIT_W-1:0] digit_c,
  output logic [DIGIT_W-1:0] digit_d,
  output logic [DIGIT_W-1:0] digit_e,
  output logic               code_valid,
  output logic               entry_busy,
  output logic [2:0]         digit_count,
  output logic               timeout_err,
  output logic               short_err
);
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]         CNT_FULL  = 3'(NUM_DIGITS);
  localparam logic [DIGIT_W-1:0] KEY_NINE  = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] KEY_CLEAR = DIGIT_W'(10);
  localparam logic [DIGIT_W-1:0] KEY_BKSP  = DIGIT_W'(11);
  localparam logic [DIGIT_W-1:0] KEY_ENTER = DIGIT_W'(14);

  typedef enum logic {S_IDLE, S_ENTRY} state_t;
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [2:0]       bksp_idx;
  digits_t          buf_q, buf_d;
  digits_t          code_q, code_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             code_valid_q, code_valid_d;
  logic             short_err_q, short_err_d;
  logic             timeout_err_q, timeout_err_d;

  assign bksp_idx = count_q - 3'd1;

  always_comb begin
    count_d       = count_q;
    buf_d         = buf_q;
    code_d        = code_q;
    timer_d       = timer_q;
    code_valid_d  = 1'b0;
    short_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (lockout) begin
      // Lockout outranks any key, including an enter in the same cycle.
      count_d = '0;
      buf_d   = '0;
      timer_d = '0;
    end else if (key_valid) begin
      timer_d = '0;
      if (key_code <= KEY_NINE) begin
        if (count_q < CNT_FULL) begin
          buf_d[count_q] = key_code;
          count_d        = count_q + 3'd1;
        end
      end else if (key_code == KEY_CLEAR) begin
        count_d = '0;
        buf_d   = '0;
      end else if (key_code == KEY_BKSP) begin
        if (count_q != 3'd0) begin
          buf_d[bksp_idx] = '0;
          count_d         = bksp_idx;
        end
      end else if (key_code == KEY_ENTER) begin
        if (count_q == CNT_FULL) begin
          code_d       = buf_q;
          code_valid_d = 1'b1;
        end else if (count_q != 3'd0) begin
          short_err_d = 1'b1;
        end
        count_d = '0;
        buf_d   = '0;
      end
    end else if (state_q == S_ENTRY) begin
      if (timer_q == TMR_LAST) begin
        timeout_err_d = 1'b1;
        count_d       = '0;
        buf_d         = '0;
        timer_d       = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    state_d = (count_d == 3'd0) ? S_IDLE : S_ENTRY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      buf_q         <= '0;
      code_q        <= '0;
      timer_q       <= '0;
      code_valid_q  <= 1'b0;
      short_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      buf_q         <= buf_d;
      code_q        <= code_d;
      timer_q       <= timer_d;
      code_valid_q  <= code_valid_d;
      short_err_q   <= short_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign digit_a     = code_q[0];
  assign digit_b     = code_q[1];
  assign digit_c     = code_q[2];
  assign digit_d     = code_q[3];
  assign digit_e     = code_q[4];
  assign code_valid  = code_valid_q;
  assign short_err   = short_err_q;
  assign timeout_err = timeout_err_q;
  assign digit_count = count_q;
  assign entry_busy  = (count_q != 3'd0);
endmodule
